// File: rtl/tt_um_operand_stager_if.sv
// Pin bundle for the operand stager tile.
// The host drives the operand/control pins; the tile drives the result/status pins.
interface tt_um_operand_stager_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_operand_stager.sv
// Two-strobe operand stager feeding an 8-bit adder; registers the sum, carry and signed overflow.
// Define ADDER_STAGE_ACCUM_EN to keep accumulating into the running sum after each ack.
module tt_um_operand_stager #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    tt_um_operand_stager_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, GOT_A, RESULT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] strobe_sync, ack_sync, clr_sync;
    logic                   strobe_prev, ack_prev;
    logic                   strobe_edge, ack_edge, clr_lvl;
    logic [7:0]             a_q, b_q, sum_q;
    logic                   carry_q, ovf_q;
    logic [8:0]             sum_full;
    logic                   load_a, load_b, reload_a, clear;

    // Each control pin gets its own synchronizer; the previous-value flops feed the edge detectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync <= '0;
            ack_sync    <= '0;
            clr_sync    <= '0;
            strobe_prev <= 1'b0;
            ack_prev    <= 1'b0;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.uio_in[0]};
            ack_sync    <= {ack_sync[SYNC_STAGES-2:0],    bus.uio_in[1]};
            clr_sync    <= {clr_sync[SYNC_STAGES-2:0],    bus.uio_in[2]};
            strobe_prev <= strobe_sync[SYNC_STAGES-1];
            ack_prev    <= ack_sync[SYNC_STAGES-1];
        end
    end

    assign strobe_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
    assign ack_edge    = ack_sync[SYNC_STAGES-1] & ~ack_prev;
    assign clr_lvl     = clr_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        reload_a = 1'b0;
        clear    = 1'b0;
        if (clr_lvl) begin
            clear   = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe_edge) begin
                        load_a  = 1'b1;
                        state_d = GOT_A;
                    end
                end
                GOT_A: begin
                    if (strobe_edge) begin
                        load_b  = 1'b1;
                        state_d = RESULT;
                    end
                end
                RESULT: begin
                    // Strobes here are dropped, and an ack in the same cycle wins.
                    if (ack_edge) begin
`ifdef ADDER_STAGE_ACCUM_EN
                        reload_a = 1'b1;
                        state_d  = GOT_A;
`else
                        state_d  = IDLE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sum_full = {1'b0, a_q} + {1'b0, bus.ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load_a)        a_q <= bus.ui_in;
            else if (reload_a) a_q <= sum_q;
            if (load_b) begin
                b_q     <= bus.ui_in;
                sum_q   <= sum_full[7:0];
                carry_q <= sum_full[8];
                ovf_q   <= (a_q[7] == bus.ui_in[7]) && (sum_full[7] != a_q[7]);
            end
        end
    end

    assign bus.uo_out  = sum_q;
    assign bus.uio_out = {state_q == GOT_A, ovf_q, carry_q, state_q == RESULT, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

    // B is kept for observability only; ena and the upper control pins have no function.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, bus.uio_in[7:3], b_q};
endmodule

// File: tb/tb_tt_um_operand_stager.sv
// Scoreboard bench for tt_um_operand_stager: expected sums are queued at stimulus and checked on valid.
module tb_tt_um_operand_stager;
    localparam int SYNC_STAGES = 2;
    localparam int GAP = SYNC_STAGES + 2;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    tt_um_operand_stager_if bus ();

    tt_um_operand_stager #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        bus.ui_in = d;
        bus.uio_in[0] = 1'b1;
        tick(GAP);
        bus.uio_in[0] = 1'b0;
        tick(GAP);
    endtask

    task automatic ack();
        bus.uio_in[1] = 1'b1;
        tick(GAP);
        bus.uio_in[1] = 1'b0;
        tick(GAP);
    endtask

    task automatic do_clear();
        bus.uio_in[2] = 1'b1;
        tick(GAP);
        bus.uio_in[2] = 1'b0;
        tick(GAP);
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        e.sum = s[7:0];
        e.carry = s[8];
        e.ovf = (a[7] == b[7]) && (s[7] != a[7]);
        sb.push_back(e);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.uio_out[4] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.ui_in = 8'($urandom);
        bus.uio_in = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h want 00", bus.uo_out); end
        n_tests++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out); end
        n_tests++; if (bus.uio_oe !== 8'hF0) begin n_fail++; $display("FAIL reset_uio_oe: got %h want F0", bus.uio_oe); end
        bus.ui_in = 8'h00;
        bus.uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        bit ok;
        exp_t e;
        strobe(8'h25);
        @(negedge clk);
        n_tests++; if (bus.uio_out !== 8'h80) begin n_fail++; $display("FAIL basic_got_a: uio_out %h want 80", bus.uio_out); end
        push_exp(8'h25, 8'h13);
        strobe(8'h13);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_valid: timeout, valid %b want 1", bus.uio_out[4]); end
        e = sb.pop_front();
        n_tests++; if (bus.uo_out !== e.sum) begin n_fail++; $display("FAIL basic_sum: got %h want %h", bus.uo_out, e.sum); end
        n_tests++; if (bus.uio_out !== {1'b0, e.ovf, e.carry, 1'b1, 4'b0}) begin n_fail++; $display("FAIL basic_flags: uio_out %h want %h", bus.uio_out, {1'b0, e.ovf, e.carry, 1'b1, 4'b0}); end
        ack();
        @(negedge clk);
        n_tests++; if (bus.uio_out[4] !== 1'b0) begin n_fail++; $display("FAIL basic_ack_valid: got %b want 0", bus.uio_out[4]); end
        n_tests++; if (bus.uo_out !== 8'h38) begin n_fail++; $display("FAIL basic_ack_hold: got %h want 38", bus.uo_out); end
    endtask

    task automatic test_wrap();
        bit ok;
        exp_t e;
        logic [7:0] pa [2];
        logic [7:0] pb [2];
        pa[0] = 8'hFF; pb[0] = 8'h01;
        pa[1] = 8'h7F; pb[1] = 8'h01;
        for (int i = 0; i < 2; i++) begin
            do_clear();
            strobe(pa[i]);
            push_exp(pa[i], pb[i]);
            strobe(pb[i]);
            wait_valid(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_valid[%0d]: timeout", i); end
            e = sb.pop_front();
            n_tests++; if ({bus.uo_out, bus.uio_out[5], bus.uio_out[6]} !== {e.sum, e.carry, e.ovf})
                begin n_fail++; $display("FAIL wrap_result[%0d]: sum/c/v %h/%b/%b want %h/%b/%b", i, bus.uo_out, bus.uio_out[5], bus.uio_out[6], e.sum, e.carry, e.ovf); end
            ack();
        end
    endtask

    task automatic test_ignored();
        bit ok;
        exp_t e;
        logic [7:0] a;
        do_clear();
        ack();
        @(negedge clk);
        n_tests++; if ({bus.uo_out, bus.uio_out} !== 16'h0000) begin n_fail++; $display("FAIL idle_ack: uo/uio %h/%h want 00/00", bus.uo_out, bus.uio_out); end
        strobe(8'h11);
        push_exp(8'h11, 8'h22);
        strobe(8'h22);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_valid: timeout"); end
        e = sb.pop_front();
        strobe(8'h99);
        @(negedge clk);
        n_tests++; if (bus.uo_out !== e.sum || bus.uio_out[4] !== 1'b1) begin n_fail++; $display("FAIL ign_extra_strobe: uo %h valid %b want %h 1", bus.uo_out, bus.uio_out[4], e.sum); end
        ack();
`ifdef ADDER_STAGE_ACCUM_EN
        a = 8'h33;
`else
        a = 8'h40;
        strobe(a);
`endif
        push_exp(a, 8'h41);
        strobe(8'h41);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_next_valid: timeout"); end
        e = sb.pop_front();
        n_tests++; if ({bus.uo_out, bus.uio_out[5], bus.uio_out[6]} !== {e.sum, e.carry, e.ovf})
            begin n_fail++; $display("FAIL ign_next_sum: sum/c/v %h/%b/%b want %h/%b/%b", bus.uo_out, bus.uio_out[5], bus.uio_out[6], e.sum, e.carry, e.ovf); end
        ack();
    endtask

    task automatic test_clear();
        bit ok;
        exp_t e;
        do_clear();
        strobe(8'h01);
        strobe(8'h02);
        ack();
`ifndef ADDER_STAGE_ACCUM_EN
        strobe(8'h5A);
`endif
        @(negedge clk);
        n_tests++; if (bus.uio_out[7] !== 1'b1 || bus.uo_out !== 8'h03) begin n_fail++; $display("FAIL clr_setup: wait_b %b uo %h want 1 03", bus.uio_out[7], bus.uo_out); end
        bus.ui_in = 8'h77;
        bus.uio_in[2] = 1'b1;
        bus.uio_in[0] = 1'b1;
        tick(GAP);
        @(negedge clk);
        n_tests++; if ({bus.uo_out, bus.uio_out} !== 16'h0000) begin n_fail++; $display("FAIL clr_priority: uo/uio %h/%h want 00/00", bus.uo_out, bus.uio_out); end
        bus.uio_in[2] = 1'b0;
        bus.uio_in[0] = 1'b0;
        tick(GAP);
        @(negedge clk);
        n_tests++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL clr_stays_idle: uio %h want 00", bus.uio_out); end
        strobe(8'h10);
        push_exp(8'h10, 8'h20);
        strobe(8'h20);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL clr_after_valid: timeout"); end
        e = sb.pop_front();
        n_tests++; if (bus.uo_out !== e.sum) begin n_fail++; $display("FAIL clr_after_sum: got %h want %h", bus.uo_out, e.sum); end
        ack();
    endtask

    task automatic test_accum();
        bit ok;
        exp_t e;
        do_clear();
        strobe(8'h10);
        push_exp(8'h10, 8'h20);
        strobe(8'h20);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL accum_first_valid: timeout"); end
        e = sb.pop_front();
        n_tests++; if (bus.uo_out !== e.sum) begin n_fail++; $display("FAIL accum_first_sum: got %h want %h", bus.uo_out, e.sum); end
        ack();
`ifdef ADDER_STAGE_ACCUM_EN
        push_exp(8'h30, 8'h05);
        strobe(8'h05);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL accum_valid: timeout"); end
        e = sb.pop_front();
        n_tests++; if (bus.uo_out !== e.sum) begin n_fail++; $display("FAIL accum_sum: got %h want %h", bus.uo_out, e.sum); end
        ack();
`else
        strobe(8'h05);
        @(negedge clk);
        n_tests++; if (bus.uo_out !== 8'h30) begin n_fail++; $display("FAIL noaccum_sum: got %h want 30", bus.uo_out); end
        n_tests++; if (bus.uio_out[4] !== 1'b0 || bus.uio_out[7] !== 1'b1) begin n_fail++; $display("FAIL noaccum_state: valid/wait_b %b/%b want 0/1", bus.uio_out[4], bus.uio_out[7]); end
`endif
    endtask

    task automatic test_held_strobe();
        do_clear();
        bus.ui_in = 8'h07;
        bus.uio_in[0] = 1'b1;
        tick(12);
        @(negedge clk);
        n_tests++; if (bus.uio_out !== 8'h80) begin n_fail++; $display("FAIL held_strobe: uio %h want 80", bus.uio_out); end
        bus.uio_in[0] = 1'b0;
        tick(GAP);
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_t e;
        logic [7:0] a, b;
        for (int i = 0; i < 4; i++) begin
            do_clear();
            a = 8'($urandom);
            b = 8'($urandom);
            strobe(a);
            push_exp(a, b);
            strobe(b);
            wait_valid(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_valid[%0d]: timeout", i); end
            e = sb.pop_front();
            n_tests++; if ({bus.uo_out, bus.uio_out[5], bus.uio_out[6]} !== {e.sum, e.carry, e.ovf})
                begin n_fail++; $display("FAIL b2b_result[%0d]: %h+%h sum/c/v %h/%b/%b want %h/%b/%b", i, a, b, bus.uo_out, bus.uio_out[5], bus.uio_out[6], e.sum, e.carry, e.ovf); end
            ack();
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        exp_t e;
        do_clear();
        strobe(8'hC0);
        push_exp(8'hC0, 8'hC0);
        strobe(8'hC0);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL arst_valid: timeout"); end
        e = sb.pop_front();
        n_tests++; if (bus.uo_out !== e.sum || bus.uio_out[5] !== e.carry) begin n_fail++; $display("FAIL arst_pre: uo %h c %b want %h %b", bus.uo_out, bus.uio_out[5], e.sum, e.carry); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({bus.uo_out, bus.uio_out} !== 16'h0000) begin n_fail++; $display("FAIL arst_async: uo/uio %h/%h want 00/00", bus.uo_out, bus.uio_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        bus.ui_in = 8'h00;
        bus.uio_in = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_ignored();
        test_clear();
        test_accum();
        test_held_strobe();
        test_back_to_back();
        test_async_reset();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_um_operand_stager.md
# tt_um_operand_stager

Sequential operand-staging adder tile. It captures two 8-bit operands one after the other from `ui_in` using a synchronized strobe, and forms their 8-bit sum with carry and signed overflow. It holds the result on the outputs until the host acknowledges it. It sits directly upstream of the combinational ripple adder stage: the operand registers it builds replace the parallel `ui_in`/`uio_in` operand pair, and the adder's sum is registered with flags.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on control inputs (legal values 2–3).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  tile enable; ignored.
- `ui_in`  in  8  operand data byte.
- `uio_in`  in  8  control inputs:
  - [0] `strobe`: load operand on rising edge.
  - [1] `ack`: release result on rising edge.
  - [2] `clr`: level, synchronous clear.
  - [7:3] ignored.
- `uo_out`  out  8  registered sum.
- `uio_out`  out  8  status outputs:
  - [4] `valid`.
  - [5] `carry`.
  - [6] `ovf`: signed overflow.
  - [7] `wait_b`.
  - [3:0] tied to 0.
- `uio_oe`  out  8  constant 8'hF0.

## Operation
- `strobe`, `ack` and `clr` each pass through a `SYNC_STAGES`-flop synchronizer.
- `strobe` and `ack` then go through a rising-edge detector: the synchronized value is high and the previous synchronized value was low.
- FSM states:
  - IDLE:
    - strobe edge → `A <= ui_in`, go to GOT_A.
    - ack edge ignored.
  - GOT_A:
    - strobe edge → go to RESULT.
    - On that same edge: `{carry, uo_out} <= A + ui_in` (9-bit, unsigned), `B <= ui_in`, `ovf <= (A[7]==ui_in[7]) && (sum[7]!=A[7])`.
    - ack edge ignored.
  - RESULT:
    - `valid` = 1.
    - strobe edges ignored and discarded; they are not queued.
    - ack edge → IDLE (or GOT_A with `ADDER_STAGE_ACCUM_EN`).
- `clr` (synchronized, level) has highest priority in every state: go to IDLE and zero A, B, `uo_out`, `carry`, `ovf`.
- A strobe edge and an ack edge in the same cycle in RESULT: ack is taken, strobe is dropped.
- Arithmetic wraps modulo 256. Example: 8'hFF + 8'h01 gives `uo_out` = 0, `carry` = 1, `ovf` = 0.
- `uo_out`, `carry` and `ovf` hold their last values after ack until the next result or a clear. Only `valid` drops.
- `wait_b` = (state == GOT_A).

## Timing
- Reset (async assert, sync release by the external reset tree):
  - state = IDLE.
  - A = B = 0.
  - `uo_out` = 0.
  - `uio_out` = 0 (`valid` = `carry` = `ovf` = `wait_b` = 0).
  - synchronizer flops = 0.
  - `uio_oe` = 8'hF0 at all times.
- Pin-to-capture latency: a strobe pin rise sampled at edge n is captured at edge n+`SYNC_STAGES`.
- Hold requirement: `ui_in` must be stable from edge n through edge n+`SYNC_STAGES`.
- `valid`, `uo_out` and flags all update on the same edge that captures B. There is zero extra latency.
- Ack: a pin rise at edge n gives `valid` = 0 at edge n+`SYNC_STAGES`.
- Clear: `clr` asserted at edge n gives all cleared values at edge n+`SYNC_STAGES`.
- A clear mid-operation (in GOT_A) discards A.
- A held-high strobe produces exactly one edge. The strobe must be seen low for at least one synchronized cycle before it can produce another edge.
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronously).

## Configuration
- `ADDER_STAGE_ACCUM_EN` defined:
  - ack in RESULT loads `A <= uo_out` and goes to GOT_A, so each subsequent strobe adds `ui_in` to the running sum.
  - `clr` is the only way back to IDLE.
- Undefined: ack in RESULT goes to IDLE and A is left unchanged. The next strobe loads a fresh A.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` = 0 with random `ui_in`/`uio_in`.
  - Required: `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'hF0.
- Basic add:
  - Stimulus: strobe 8'h25, then strobe 8'h13.
  - Required: `uo_out` = 8'h38, `valid` = 1, `carry` = 0, `ovf` = 0, `wait_b` = 0.
  - Then ack: `valid` = 0 and `uo_out` stays 8'h38.
- Wrap and flags:
  - Stimulus: 8'hFF + 8'h01.
  - Required: `uo_out` = 0, `carry` = 1, `ovf` = 0.
  - Stimulus: 8'h7F + 8'h01.
  - Required: `uo_out` = 8'h80, `carry` = 0, `ovf` = 1.
- Ignored events:
  - Stimulus: ack in IDLE.
  - Required: no change.
  - Stimulus: an extra strobe of 8'h99 in RESULT, then ack.
  - Required: `uo_out` is unchanged and the next operand pair adds correctly.
- Clear priority:
  - Stimulus: in GOT_A, assert `clr` together with a strobe edge.
  - Required: state is IDLE, all outputs are 0, and the strobe has no effect.
- Accumulate (macro defined):
  - Stimulus: strobe 8'h10 and 8'h20, ack, strobe 8'h05.
  - Required: `uo_out` = 8'h35 with `valid` = 1.
- Accumulate (macro undefined):
  - Stimulus: the same sequence.
  - Required: `uo_out` remains 8'h30, `valid` = 0, `wait_b` = 1.
